alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
- Next-generation execute unit for the CPU datapath.
- Width-parametrised ALU with a valid/ready handshake on input and output.
- Adds signed/unsigned compare, arithmetic shift, NOR, overflow/zero flags, and iterative unsigned multiply/divide with architectural HI/LO registers.
- Sits between the register-read stage and writeback; the controller stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of in-flight op and pending result.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation this cycle.
- SrcA  input  WIDTH  operand A; shift amount is SrcA[SHW-1:0].
- SrcB  input  WIDTH  operand B.
- ALUControl  input  4  opcode.
- out_valid  output  1  Result/flags valid.
- out_ready  input  1  consumer accepts result.
- Result  output  WIDTH  registered result.
- Zero  output  1  Result == 0.
- Overflow  output  1  signed overflow; ADD/SUB only, else 0.
- DivZero  output  1  DIVU with SrcB == 0.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; out_valid=0; Result=0; Zero=0; Overflow=0; DivZero=0; HI=0; LO=0.
  - Reset mid-multiply/divide discards the operation.
- Handshake:
  - in_ready = (state==IDLE) && !out_valid.
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - out_valid holds, with Result and flags stable, until out_ready is sampled high; it clears on that edge.
  - No new op is accepted in the same cycle a result drains; the next op is accepted the following cycle.
- Opcodes, single-cycle (out_valid rises the edge after acceptance):
  - 0 AND; 1 OR; 2 ADD; 3 SUB.
  - 4 SLL: SrcB<<sh. 5 SRL: SrcB>>sh, logical. 8 SRA: SrcB>>>sh, signed.
  - 6 XOR; 7 LUI: SrcB<<(WIDTH/2); 15 NOR.
  - 9 SLT: signed A<B → 1, else 0. 10 SLTU: unsigned.
  - 13 MFHI: Result=HI. 14 MFLO: Result=LO.
  - ADD/SUB wrap modulo 2^WIDTH. Overflow = signed overflow of that operation.
- Opcode 11 MULTU:
  - Shift-add state MUL, exactly WIDTH iteration cycles.
  - {HI,LO} = A*B (2*WIDTH-bit).
  - Result = LO; out_valid rises WIDTH+1 edges after acceptance.
- Opcode 12 DIVU:
  - Restoring divide state DIV, WIDTH iteration cycles.
  - LO = A/B, HI = A%B; Result = quotient; latency WIDTH+1.
  - If SrcB==0: no iteration; completes in 1 cycle with LO = all ones, HI = SrcA, Result = all ones, DivZero = 1.
- HI/LO are written only when MULTU/DIVU completes; they are untouched by flush or by other ops.
- FSM:
  - IDLE → MUL/DIV on acceptance of 11/12 (except div-by-zero), else stays in IDLE.
  - MUL/DIV → IDLE when the iteration counter reaches WIDTH-1, with result registered the same edge.
- Zero is computed from the final Result for every op.
- flush (synchronous, dominant over all other inputs that cycle):
  - state → IDLE, out_valid → 0, iteration counter cleared, HI/LO unchanged.
  - An op offered in the flush cycle is not accepted; in_ready is forced 0 during flush.
- Illegal/unused opcodes: none; all 16 codes are defined.

Test Plan:
- ADD 0x7FFFFFFF+1, out_ready=1 → next cycle out_valid=1, Result=0x80000000, Overflow=1, Zero=0. Then SUB 5-5 → Result=0, Zero=1, Overflow=0.
- SRA SrcB=0x80000000, SrcA=0x24 (sh=4) → Result=0xF8000000; SRL → 0x08000000; SLT A=-1, B=1 → 1; SLTU same operands → 0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF → in_ready low 32 cycles, out_valid at edge 33, Result=LO=0x00000001; MFHI → 0xFFFFFFFE.
- DIVU 100/7 → Result=14 after 33 edges, MFHI → 2. DIVU 9/0 → 1-cycle, Result=0xFFFFFFFF, DivZero=1, then MFHI → 9.
- Backpressure: out_ready=0 for 5 cycles after XOR result → Result stable, in_ready=0 throughout; in_valid held on a new op is accepted the cycle after out_ready=1.
- flush at cycle 10 of MULTU → out_valid never rises, in_ready=1 next cycle, MFHI returns the prior HI. Async rst_n low mid-DIVU → all outputs 0 immediately.
- Re-run the ADD/SLL/MULTU cases with WIDTH=16 → SLL uses SrcA[3:0], MULTU latency 17.

Source files
------------

// File: rtl/alu_muldiv_if.sv
// Valid/ready operation and result bus of the alu_muldiv execute unit.
// The master drives operands and accepts results; the slave is the execute unit.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;
  logic             DivZero;

  modport master (
    output in_valid, SrcA, SrcB, ALUControl, out_ready,
    input  in_ready, out_valid, Result, Zero, Overflow, DivZero
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUControl, out_ready,
    output in_ready, out_valid, Result, Zero, Overflow, DivZero
  );
endinterface

// File: rtl/alu_muldiv.sv
// Execute unit: single-cycle ALU ops plus iterative unsigned multiply/divide
// writing architectural HI/LO, with a valid/ready handshake on both sides.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  alu_muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_e;

  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                         OP_SLL = 4'd4, OP_SRL = 4'd5, OP_XOR = 4'd6, OP_LUI = 4'd7,
                         OP_SRA = 4'd8, OP_SLT = 4'd9, OP_SLTU = 4'd10, OP_MULTU = 4'd11,
                         OP_DIVU = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_NOR = 4'd15;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {HI-part, LO-part} working register
  logic [WIDTH-1:0]   opb_q, opb_d;       // multiplicand or divisor
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic               out_valid_q, out_valid_d, zero_q, zero_d;
  logic               ovf_q, ovf_d, dz_q, dz_d;

  logic               accept_s, alu_ovf_s;
  logic [SHW-1:0]     sh_s;
  logic [WIDTH-1:0]   alu_res_s, add_s, sub_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s, div_diff_s;
  logic [2*WIDTH-1:0] acc_next_s;

  assign sh_s     = bus.SrcA[SHW-1:0];
  assign add_s    = bus.SrcA + bus.SrcB;
  assign sub_s    = bus.SrcA - bus.SrcB;
  assign accept_s = bus.in_valid && bus.in_ready;

  // Single-cycle ALU result and signed-overflow flag
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (bus.ALUControl)
      OP_AND:  alu_res_s = bus.SrcA & bus.SrcB;
      OP_OR:   alu_res_s = bus.SrcA | bus.SrcB;
      OP_ADD: begin
        alu_res_s = add_s;
        alu_ovf_s = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) && (add_s[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = sub_s;
        alu_ovf_s = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) && (sub_s[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      OP_SLL:  alu_res_s = bus.SrcB << sh_s;
      OP_SRL:  alu_res_s = bus.SrcB >> sh_s;
      OP_XOR:  alu_res_s = bus.SrcA ^ bus.SrcB;
      OP_LUI:  alu_res_s = bus.SrcB << (WIDTH / 2);
      OP_SRA:  alu_res_s = $signed(bus.SrcB) >>> sh_s;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
      OP_MFHI: alu_res_s = hi_q;
      OP_MFLO: alu_res_s = lo_q;
      OP_NOR:  alu_res_s = ~(bus.SrcA | bus.SrcB);
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add or restoring-divide step on the working register
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_trial_s = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_trial_s - {1'b0, opb_q};
    if (state_q == S_DIV) begin
      if (!div_diff_s[WIDTH]) begin
        acc_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  // Next-state, datapath and result-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = {SHW{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            cnt_d = {SHW{1'b0}};
            if (bus.ALUControl == OP_MULTU) begin
              state_d = S_MUL;
              acc_d   = {{WIDTH{1'b0}}, bus.SrcB};
              opb_d   = bus.SrcA;
            end else if (bus.ALUControl == OP_DIVU && bus.SrcB == {WIDTH{1'b0}}) begin
              lo_d        = {WIDTH{1'b1}};
              hi_d        = bus.SrcA;
              result_d    = {WIDTH{1'b1}};
              ovf_d       = 1'b0;
              dz_d        = 1'b1;
              out_valid_d = 1'b1;
            end else if (bus.ALUControl == OP_DIVU) begin
              state_d = S_DIV;
              acc_d   = {{WIDTH{1'b0}}, bus.SrcA};
              opb_d   = bus.SrcB;
            end else begin
              result_d    = alu_res_s;
              ovf_d       = alu_ovf_s;
              dz_d        = 1'b0;
              out_valid_d = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          acc_d = acc_next_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // Upper half is product-high or remainder, lower half product-low or quotient
            state_d     = S_IDLE;
            cnt_d       = {SHW{1'b0}};
            hi_d        = acc_next_s[2*WIDTH-1:WIDTH];
            lo_d        = acc_next_s[WIDTH-1:0];
            result_d    = acc_next_s[WIDTH-1:0];
            ovf_d       = 1'b0;
            dz_d        = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    zero_d = (result_d == {WIDTH{1'b0}});
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {SHW{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !out_valid_q && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Zero      = zero_q;
  assign bus.Overflow  = ovf_q;
  assign bus.DivZero   = dz_q;
endmodule
